fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage pipelined processor: owns the PC, drives address_imem,

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage_fd_latch.sv | 55 +++++
 rtl/fetch_stage.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg: shared processor definitions for the fetch stage.
//   PC_WIDTH / INSN_WIDTH / CNT_WIDTH : default datapath widths
//   RESET_PC                          : PC loaded on reset
//   NOP_INSN                          : bubble instruction for F/D
//   fetch_state_t                     : RUN / STALL / FLUSH
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int unsigned PC_WIDTH   = 12;
    localparam int unsigned INSN_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 16;

    localparam logic [PC_WIDTH-1:0]   RESET_PC = 12'h000;
    localparam logic [INSN_WIDTH-1:0] NOP_INSN = 32'h0000_0000;

    // Explicit encodings keep the values identical to the legacy constants.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if: instruction-memory bus between fetch and imem.
//   address_imem : word address (current PC), driven by fetch
//   q_imem       : instruction at address_imem, driven by imem
//   master modport -> fetch stage, slave modport -> instruction memory
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int unsigned PC_WIDTH   = proc_pkg::PC_WIDTH,
    parameter int unsigned INSN_WIDTH = proc_pkg::INSN_WIDTH
) ();

    logic [PC_WIDTH-1:0]   address_imem;
    logic [INSN_WIDTH-1:0] q_imem;

    modport master (
        output address_imem,
        input  q_imem
    );

    modport slave (
        input  address_imem,
        output q_imem
    );

endinterface

// File: rtl/fetch_stage_fd_latch.sv
// ---------------------------------------------------------------------------
// fd_latch: F/D pipeline register bank (insn, pc, pc_plus1, valid).
//   clock, reset     : clock / async active-high reset
//   i_flush          : load NOP_INSN, clear valid, hold pc fields (wins)
//   i_load           : capture i_insn/i_pc/i_pc_plus1, set valid
//   neither asserted : hold all fields
//   o_*              : registered F/D contents
// ---------------------------------------------------------------------------
module fd_latch #(
    parameter int unsigned            PC_WIDTH   = proc_pkg::PC_WIDTH,
    parameter int unsigned            INSN_WIDTH = proc_pkg::INSN_WIDTH,
    parameter logic [INSN_WIDTH-1:0]  NOP_INSN   = proc_pkg::NOP_INSN
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic [INSN_WIDTH-1:0] i_insn,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic [PC_WIDTH-1:0]   i_pc_plus1,
    output logic [INSN_WIDTH-1:0] o_insn,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [PC_WIDTH-1:0]   o_pc_plus1,
    output logic                  o_valid
);

    logic [INSN_WIDTH-1:0] r_insn;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_pc_plus1;
    logic                  r_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_insn     <= NOP_INSN;
            r_pc       <= '0;
            r_pc_plus1 <= PC_WIDTH'(1);
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            // pc fields keep the last real instruction's values
            r_insn     <= NOP_INSN;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_insn     <= i_insn;
            r_pc       <= i_pc;
            r_pc_plus1 <= i_pc_plus1;
            r_valid    <= 1'b1;
        end
    end

    assign o_insn     = r_insn;
    assign o_pc       = r_pc;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage of the 5-stage pipeline.
//   clock, reset        : clock / async active-high reset
//   stall               : hold PC and F/D this cycle
//   redirect            : branch/jump resolved in MEM, reload PC (beats stall)
//   redirect_target     : new PC when redirect=1
//   imem (master)       : address_imem = PC register, q_imem = fetched insn
//   fd_insn/fd_pc/fd_pc_plus1/fd_valid : F/D pipeline latch
//   stall_count         : saturating count of stall-only cycles
//   redirect_count      : saturating count of redirect cycles
//   fetch_state         : RUN / STALL / FLUSH, for debug visibility
// ---------------------------------------------------------------------------
module fetch_stage
    import proc_pkg::*;
#(
    parameter int unsigned           PC_WIDTH   = proc_pkg::PC_WIDTH,
    parameter int unsigned           INSN_WIDTH = proc_pkg::INSN_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = proc_pkg::RESET_PC,
    parameter logic [INSN_WIDTH-1:0] NOP_INSN   = proc_pkg::NOP_INSN,
    parameter int unsigned           CNT_WIDTH  = proc_pkg::CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_target,
    fetch_stage_if.master         imem,
    output logic [INSN_WIDTH-1:0] fd_insn,
    output logic [PC_WIDTH-1:0]   fd_pc,
    output logic [PC_WIDTH-1:0]   fd_pc_plus1,
    output logic                  fd_valid,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  redirect_count,
    output fetch_state_t          fetch_state
);

    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_plus1;
    logic                 w_load;
    logic                 w_stall_only;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic [CNT_WIDTH-1:0] r_redirect_count;
    fetch_state_t         r_state;
    fetch_state_t         w_state_next;

    // Wraps naturally modulo 2^PC_WIDTH.
    assign w_pc_plus1   = r_pc + PC_WIDTH'(1);
    assign w_stall_only = stall && !redirect;
    assign w_load       = !stall && !redirect;

    // PC register drives the imem address directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_target;
        end else if (!stall) begin
            r_pc <= w_pc_plus1;
        end
    end

    assign imem.address_imem = r_pc;

    always_comb begin
        w_state_next = RUN;
        if (redirect) begin
            w_state_next = FLUSH;
        end else if (stall) begin
            w_state_next = STALL;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Saturating event counters: stop at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_count    <= '0;
            r_redirect_count <= '0;
        end else begin
            if (w_stall_only && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_WIDTH'(1);
            end
            if (redirect && (r_redirect_count != '1)) begin
                r_redirect_count <= r_redirect_count + CNT_WIDTH'(1);
            end
        end
    end

    fd_latch #(
        .PC_WIDTH   (PC_WIDTH),
        .INSN_WIDTH (INSN_WIDTH),
        .NOP_INSN   (NOP_INSN)
    ) u_fd_latch (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_flush    (redirect),
        .i_insn     (imem.q_imem),
        .i_pc       (r_pc),
        .i_pc_plus1 (w_pc_plus1),
        .o_insn     (fd_insn),
        .o_pc       (fd_pc),
        .o_pc_plus1 (fd_pc_plus1),
        .o_valid    (fd_valid)
    );

    assign stall_count    = r_stall_count;
    assign redirect_count = r_redirect_count;
    assign fetch_state    = r_state;

endmodule
